comp_window_monitor: RTL and testbench



---
 rtl/comp_window_monitor.sv | 105 ++++++++++
 tb/tb_comp_window_monitor.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/comp_window_monitor.sv
// comp_window_monitor: tallies comparator codes over WINDOW accepted samples and reports them via valid/ready.
// Define COMP_WINDOW_MONITOR_ERR_EN to count illegal codes toward the window; otherwise they are dropped.
module comp_window_monitor #(
    parameter int WINDOW = 8,
    parameter int CNT_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       R,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] max_eq_run
);
    typedef enum logic {ACCUM, REPORT} state_e;
    state_e state_q;
    logic in_ready_q, out_valid_q;
    logic [CNT_W-1:0] gt_q, eq_q, lt_q, err_q, smp_q, run_q, max_q;
    logic [CNT_W-1:0] gt_d, eq_d, lt_d, err_d, smp_d, run_d, max_d;
    logic [CNT_W-1:0] gt_cnt_q, eq_cnt_q, lt_cnt_q, err_cnt_q, max_eq_run_q;
    logic is_gt, is_eq, is_lt, is_err, counted, accept, last;
    always_comb begin
        is_gt   = R == 3'b100;
        is_eq   = R == 3'b010;
        is_lt   = R == 3'b001;
        is_err  = !(is_gt || is_eq || is_lt);
`ifdef COMP_WINDOW_MONITOR_ERR_EN
        counted = 1'b1;
        err_d   = err_q + CNT_W'(is_err);
`else
        counted = !is_err;
        err_d   = '0;
`endif
        accept  = in_valid && in_ready_q;
        last    = accept && counted && (smp_q == CNT_W'(WINDOW - 1));
        gt_d    = gt_q + CNT_W'(is_gt);
        eq_d    = eq_q + CNT_W'(is_eq);
        lt_d    = lt_q + CNT_W'(is_lt);
        smp_d   = smp_q + CNT_W'(counted);
        // dropped illegal codes leave the equal run untouched
        run_d   = is_eq ? run_q + 1'b1 : (counted ? '0 : run_q);
        max_d   = (run_d > max_q) ? run_d : max_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ACCUM;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            gt_q         <= '0;
            eq_q         <= '0;
            lt_q         <= '0;
            err_q        <= '0;
            smp_q        <= '0;
            run_q        <= '0;
            max_q        <= '0;
            gt_cnt_q     <= '0;
            eq_cnt_q     <= '0;
            lt_cnt_q     <= '0;
            err_cnt_q    <= '0;
            max_eq_run_q <= '0;
        end else if (state_q == ACCUM) begin
            in_ready_q  <= !last;
            out_valid_q <= last;
            if (last) begin
                state_q      <= REPORT;
                gt_cnt_q     <= gt_d;
                eq_cnt_q     <= eq_d;
                lt_cnt_q     <= lt_d;
                err_cnt_q    <= err_d;
                max_eq_run_q <= max_d;
                gt_q         <= '0;
                eq_q         <= '0;
                lt_q         <= '0;
                err_q        <= '0;
                smp_q        <= '0;
                run_q        <= '0;
                max_q        <= '0;
            end else if (accept) begin
                gt_q  <= gt_d;
                eq_q  <= eq_d;
                lt_q  <= lt_d;
                err_q <= err_d;
                smp_q <= smp_d;
                run_q <= run_d;
                max_q <= max_d;
            end
        end else if (out_ready) begin
            state_q     <= ACCUM;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end
    end
    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign gt_cnt     = gt_cnt_q;
    assign eq_cnt     = eq_cnt_q;
    assign lt_cnt     = lt_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign max_eq_run = max_eq_run_q;
endmodule

// File: tb/tb_comp_window_monitor.sv
// tb_comp_window_monitor: directed and randomized checks of comp_window_monitor with WINDOW=8, CNT_W=4.
module tb_comp_window_monitor;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [2:0] R;
    logic [3:0] gt_cnt, eq_cnt, lt_cnt, err_cnt, max_eq_run;
    int n_chk = 0;
    int n_fail = 0;
    logic [2:0]  codes [3] = '{3'b100, 3'b010, 3'b001};
    logic [15:0] exp_q [$];
    logic [15:0] e;
    logic [3:0]  mg, me, ml, mr, mm, mn;
    int sent, got, cyc;

    comp_window_monitor #(.WINDOW(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .R(R),
        .out_valid(out_valid), .out_ready(out_ready), .gt_cnt(gt_cnt), .eq_cnt(eq_cnt),
        .lt_cnt(lt_cnt), .err_cnt(err_cnt), .max_eq_run(max_eq_run)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got_v, input int exp_v);
        n_chk++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got_v, exp_v);
        end
    endtask

    // called at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic [2:0] code);
        int n = 0;
        in_valid = 1'b1;
        R = code;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_wait", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_rep(input string tag, input int g, input int q, input int l, input int er, input int m);
        check({tag, "_ov"}, out_valid, 1);
        check({tag, "_gt"}, gt_cnt, g);
        check({tag, "_eq"}, eq_cnt, q);
        check({tag, "_lt"}, lt_cnt, l);
        check({tag, "_err"}, err_cnt, er);
        check({tag, "_run"}, max_eq_run, m);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        R = 3'b000;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ir", in_ready, 0);
        check("rst_ov", out_valid, 0);
        check("rst_gt", gt_cnt, 0);
        check("rst_run", max_eq_run, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ir", in_ready, 1);

        out_ready = 1'b1;
        repeat (7) send(3'b100);
        check("t1_pre_ov", out_valid, 0);
        send(3'b100);
        check_rep("t1", 8, 0, 0, 0, 0);
        @(negedge clk);
        check("t1_done_ov", out_valid, 0);
        check("t1_done_ir", in_ready, 1);

        foreach (codes[i]) begin end
        send(3'b010); send(3'b010); send(3'b100); send(3'b010);
        send(3'b010); send(3'b010); send(3'b001); send(3'b010);
        check_rep("t2", 1, 6, 1, 0, 3);
        @(negedge clk);

        out_ready = 1'b0;
        repeat (4) send(3'b100);
        repeat (4) send(3'b001);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            R = 3'b010;
            check("t3_hold_ir", in_ready, 0);
            check_rep("t3_hold", 4, 0, 4, 0, 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_rel_ir", in_ready, 1);
        check("t3_rel_ov", out_valid, 0);
        check("t3_keep_gt", gt_cnt, 4);

        send(3'b000); send(3'b100); send(3'b110); send(3'b010);
        send(3'b010); send(3'b001); send(3'b010); send(3'b100);
`ifdef COMP_WINDOW_MONITOR_ERR_EN
        check_rep("t4", 2, 3, 1, 2, 2);
        check("t4_sum", gt_cnt + eq_cnt + lt_cnt + err_cnt, 8);
`else
        check("t4_wait_ov", out_valid, 0);
        send(3'b010); send(3'b010);
        check_rep("t4", 2, 5, 1, 0, 2);
`endif
        @(negedge clk);

        repeat (5) send(3'b100);
        rst_n = 1'b0;
        #1;
        check("t5_rst_ir", in_ready, 0);
        check("t5_rst_ov", out_valid, 0);
        check("t5_rst_gt", gt_cnt, 0);
        check("t5_rst_eq", eq_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        repeat (7) send(3'b001);
        check("t5_pre_ov", out_valid, 0);
        send(3'b001);
        check_rep("t5", 0, 0, 8, 0, 0);
        @(negedge clk);

        sent = 0; got = 0; cyc = 0;
        mg = 0; me = 0; ml = 0; mr = 0; mm = 0; mn = 0;
        while ((sent < 64 || got < 8) && cyc < 3000) begin
            in_valid = (sent < 64) && ($urandom_range(0, 1) == 1);
            R = codes[$urandom_range(0, 2)];
            out_ready = ($urandom_range(0, 1) == 1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("rnd_extra_ov", out_valid, 0);
                else begin
                    e = exp_q.pop_front();
                    check("rnd_gt", gt_cnt, e[15:12]);
                    check("rnd_eq", eq_cnt, e[11:8]);
                    check("rnd_lt", lt_cnt, e[7:4]);
                    check("rnd_run", max_eq_run, e[3:0]);
                    check("rnd_sum", gt_cnt + eq_cnt + lt_cnt + err_cnt, 8);
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                sent++;
                mg += (R == 3'b100) ? 4'd1 : 4'd0;
                me += (R == 3'b010) ? 4'd1 : 4'd0;
                ml += (R == 3'b001) ? 4'd1 : 4'd0;
                mr = (R == 3'b010) ? mr + 4'd1 : 4'd0;
                if (mr > mm) mm = mr;
                mn++;
                if (mn == 8) begin
                    exp_q.push_back({mg, me, ml, mm});
                    mg = 0; me = 0; ml = 0; mr = 0; mm = 0; mn = 0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check("rnd_reports", got, 8);
        check("rnd_sent", sent, 64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
